cnu_row_sequencer: RTL and testbench
====================================

// Module: cnu_row_sequencer
// PURPOSE
//  Sequences one check-node row update of the min-sum LDPC decoder around the q-r loop-reduce datapath.
//  Phase 1 reads DEG (q,r) pairs and strobes the datapath's load_temp.
//  Phase 1 also folds the registered sign/|q-r| results into min1/min2/min1_idx/sign parity.
//  Phase 2 writes DEG new offset-min-sum r messages back with a ready handshake.
//  Sits between the row scheduler (start/done) and the q/r memories plus loop-reduce slice.
// PARAMETERS
//  DEG     6  check-row weight (columns per row), >=2
//  MAG_W   8  magnitude width, equal to iniBW+exBW of the datapath
//  IDX_W   3  column index width, 2^IDX_W >= DEG
//  OFFSET  0  offset subtracted from output magnitude (offset min-sum), unsigned, < 2^MAG_W
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request one row update; sampled only in IDLE
//  busy       out  1      high in every state except IDLE
//  done       out  1      one-cycle pulse in DONE state
//  rd_en      out  1      q/r memory read strobe; memory returns data 1 cycle later
//  rd_col     out  IDX_W  column index of the read
//  load_temp  out  1      datapath load strobe (= rd_en delayed 1 cycle)
//  dp_sign    in   1      registered sign of q-r from datapath
//  dp_mag     in   MAG_W  registered |q-r| from datapath, treated as unsigned
//  wr_en      out  1      r write request; held until accepted
//  wr_ready   in   1      write accepted when wr_en & wr_ready at clock edge
//  wr_col     out  IDX_W  column index of write
//  wr_sign    out  1      new r sign
//  wr_mag     out  MAG_W  new r magnitude
// BEHAVIOUR
//  Reset: state IDLE; busy, done, rd_en, load_temp, wr_en = 0.
//  Reset: rd_col, wr_col, wr_sign, wr_mag = 0; min1, min2 = all-ones; min1_idx, sign_prod, sign_vec = 0.
//  Reset mid-operation aborts immediately; no partial write is completed.
//  FSM: IDLE -> COLLECT on start (min regs re-initialised, sign_prod=0, col cnt=0).
//  FSM: COLLECT (DEG cycles) -> DRAIN (2 cycles) -> WRITE -> DONE (1 cycle) -> IDLE.
//  start outside IDLE is ignored; it is not queued.
//  COLLECT: rd_en=1, rd_col=0..DEG-1, one column per cycle.
//  load_temp = rd_en delayed 1 cycle, and covers DRAIN cycle 0.
//  Fold: dp_sign/dp_mag are sampled 2 cycles after rd_en for column k (internal 2-deep valid/index pipe).
//  Fold: sign_vec[k] <= dp_sign; sign_prod ^= dp_sign.
//  Fold: if dp_mag < min1 then {min2,min1,min1_idx} <= {min1,dp_mag,k}; else if dp_mag < min2 then min2 <= dp_mag.
//  Ties use strict <: an equal value goes to min2 and min1_idx keeps the first column.
//  The last fold lands at the end of DRAIN cycle 1.
//  WRITE: wr_en=1, wr_col=k, starting at k=0.
//  WRITE: m = (k==min1_idx) ? min2 : min1; wr_mag = (m > OFFSET) ? m-OFFSET : 0 (saturates at 0).
//  WRITE: wr_sign = sign_prod ^ sign_vec[k].
//  WRITE: k advances only on wr_en & wr_ready; outputs stay stable while stalled.
//  WRITE -> DONE after column DEG-1 is accepted.
//  Latency with wr_ready=1: rd_en cycles 0..DEG-1 after the start edge, wr_en cycles DEG+2..2DEG+1, done at cycle 2DEG+2.
//  Outputs are registered; wr_en/wr_col/wr_sign/wr_mag are 0 outside WRITE.
// TESTING
//  T1 DEG=6, OFFSET=0, mags [5,2,9,4,7,12], signs [0,1,1,0,0,0], wr_ready=1
//     -> wr_mag [2,4,2,2,2,2], wr_sign [0,1,1,0,0,0], done at cycle 14.
//  T2 same data with sign col5=1
//     -> sign_prod=1, wr_sign [1,0,0,1,1,0].
//  T3 OFFSET=3, same mags as T1
//     -> wr_mag [0,1,0,0,0,0] (saturation at 0 on 2-3).
//  T4 ties: mags [3,3,8,8,8,8]
//     -> min1_idx=0, min2=3, wr_mag all 3.
//  T5 wr_ready low 3 cycles at col 2
//     -> wr_col=2 and wr_mag/wr_sign held, no skip, done delayed 3 cycles; start pulsed while busy is ignored.
//  T6 rst_n asserted mid-COLLECT
//     -> all outputs 0 immediately, FSM IDLE; a fresh start afterwards gives T1 results.

Source files
------------

// File: rtl/cnu_row_sequencer_if.sv
// Handshake and data bundle between the CNU row sequencer, the q/r memories and the
// loop-reduce datapath slice.
interface cnu_row_sequencer_if #(
  parameter int unsigned MAG_W = 8,
  parameter int unsigned IDX_W = 3
) ();
  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [IDX_W-1:0] rd_col;
  logic             load_temp;
  logic             dp_sign;
  logic [MAG_W-1:0] dp_mag;
  logic             wr_en;
  logic             wr_ready;
  logic [IDX_W-1:0] wr_col;
  logic             wr_sign;
  logic [MAG_W-1:0] wr_mag;

  modport master (
    input  start, dp_sign, dp_mag, wr_ready,
    output busy, done, rd_en, rd_col, load_temp, wr_en, wr_col, wr_sign, wr_mag
  );

  modport slave (
    output start, dp_sign, dp_mag, wr_ready,
    input  busy, done, rd_en, rd_col, load_temp, wr_en, wr_col, wr_sign, wr_mag
  );
endinterface

// File: rtl/cnu_row_sequencer.sv
// Sequences one min-sum check-node row update: collect DEG (q,r) results, fold them into
// min1/min2/sign parity, then write back DEG offset-min-sum r messages.
module cnu_row_sequencer #(
  parameter int unsigned DEG    = 6,
  parameter int unsigned MAG_W  = 8,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned OFFSET = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  cnu_row_sequencer_if.master  bus
);

  typedef enum logic [2:0] {StIdle, StCollect, StDrain, StWrite, StDone} state_e;

  localparam logic [IDX_W-1:0] LastCol   = IDX_W'(DEG - 1);
  localparam logic [IDX_W-1:0] OneCol    = IDX_W'(1);
  localparam logic [MAG_W-1:0] OffsetMag = MAG_W'(OFFSET);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               init;

  logic               load_temp_q;
  logic [IDX_W-1:0]   idx1_q, idx2_q;
  logic               fold_q;

  logic [MAG_W-1:0]   min1_q, min2_q;
  logic [IDX_W-1:0]   min1_idx_q;
  logic               sign_prod_q;
  logic [2**IDX_W-1:0] sign_vec_q;

  logic               wr_active;
  logic [MAG_W-1:0]   sel_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StCollect;
          cnt_d   = '0;
          init    = 1'b1;
        end
      end
      StCollect: begin
        if (cnt_q == LastCol) begin
          state_d = StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + OneCol;
        end
      end
      StDrain: begin
        if (cnt_q == OneCol) begin
          state_d = StWrite;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + OneCol;
        end
      end
      StWrite: begin
        if (bus.wr_ready) begin
          if (cnt_q == LastCol) begin
            state_d = StDone;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + OneCol;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Two-deep valid/index pipe: datapath result for column k is valid two cycles after its read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_temp_q <= 1'b0;
      idx1_q      <= '0;
      fold_q      <= 1'b0;
      idx2_q      <= '0;
    end else begin
      load_temp_q <= (state_q == StCollect);
      idx1_q      <= cnt_q;
      fold_q      <= load_temp_q;
      idx2_q      <= idx1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1_q      <= '1;
      min2_q      <= '1;
      min1_idx_q  <= '0;
      sign_prod_q <= 1'b0;
      sign_vec_q  <= '0;
    end else if (init) begin
      min1_q      <= '1;
      min2_q      <= '1;
      min1_idx_q  <= '0;
      sign_prod_q <= 1'b0;
      sign_vec_q  <= '0;
    end else if (fold_q) begin
      // Strict compare: a tie keeps the earlier column as min1 and drops the new value to min2.
      if (bus.dp_mag < min1_q) begin
        min2_q     <= min1_q;
        min1_q     <= bus.dp_mag;
        min1_idx_q <= idx2_q;
      end else if (bus.dp_mag < min2_q) begin
        min2_q <= bus.dp_mag;
      end
      sign_vec_q[idx2_q] <= bus.dp_sign;
      sign_prod_q        <= sign_prod_q ^ bus.dp_sign;
    end
  end

  // All outputs decode flops only, so no input reaches an output combinationally.
  assign wr_active     = (state_q == StWrite);
  assign sel_mag       = (cnt_q == min1_idx_q) ? min2_q : min1_q;

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.rd_en     = (state_q == StCollect);
  assign bus.rd_col    = (state_q == StCollect) ? cnt_q : '0;
  assign bus.load_temp = load_temp_q;
  assign bus.wr_en     = wr_active;
  assign bus.wr_col    = wr_active ? cnt_q : '0;
  assign bus.wr_sign   = wr_active & (sign_prod_q ^ sign_vec_q[cnt_q]);
  assign bus.wr_mag    = (wr_active && (sel_mag > OffsetMag)) ? (sel_mag - OffsetMag) : '0;

endmodule

// File: tb/tb_cnu_row_sequencer.sv
// Row-level bench: two sequencers (offset 0 and 3) share a memory/datapath model and are
// checked each cycle against a min-of-others / xor-of-others reference.
module tb_cnu_row_sequencer;
  localparam int unsigned DEG   = 6;
  localparam int unsigned MAG_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned OFF1  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 1'b0;
  logic             wr_ready = 1'b0;
  logic             dp_sign;
  logic [MAG_W-1:0] dp_mag;

  cnu_row_sequencer_if #(.MAG_W(MAG_W), .IDX_W(IDX_W)) bus0 ();
  cnu_row_sequencer_if #(.MAG_W(MAG_W), .IDX_W(IDX_W)) bus1 ();

  assign bus0.start    = start;
  assign bus0.wr_ready = wr_ready;
  assign bus0.dp_sign  = dp_sign;
  assign bus0.dp_mag   = dp_mag;
  assign bus1.start    = start;
  assign bus1.wr_ready = wr_ready;
  assign bus1.dp_sign  = dp_sign;
  assign bus1.dp_mag   = dp_mag;

  cnu_row_sequencer #(.DEG(DEG), .MAG_W(MAG_W), .IDX_W(IDX_W), .OFFSET(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  cnu_row_sequencer #(.DEG(DEG), .MAG_W(MAG_W), .IDX_W(IDX_W), .OFFSET(OFF1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;
  int mag_a[DEG];
  bit sig_a[DEG];

  // Memory returns data one cycle after rd_en; the datapath register loads on load_temp.
  logic [IDX_W-1:0] col_d1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_d1  <= '0;
      dp_sign <= 1'b0;
      dp_mag  <= '0;
    end else begin
      col_d1 <= bus0.rd_col;
      if (bus0.load_temp) begin
        dp_sign <= sig_a[col_d1];
        dp_mag  <= MAG_W'(mag_a[col_d1]);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_mag(input int k, input int off);
    int m = 1 << 30;
    for (int j = 0; j < DEG; j++) if (j != k && mag_a[j] < m) m = mag_a[j];
    return (m > off) ? m - off : 0;
  endfunction

  function automatic bit exp_sign(input int k);
    bit p = 1'b0;
    for (int j = 0; j < DEG; j++) if (j != k) p ^= sig_a[j];
    return p;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, bus0.busy, 0);
    check_eq({tag, "_done"}, bus0.done, 0);
    check_eq({tag, "_rd_en"}, bus0.rd_en, 0);
    check_eq({tag, "_rd_col"}, bus0.rd_col, 0);
    check_eq({tag, "_load_temp"}, bus0.load_temp, 0);
    check_eq({tag, "_wr_en"}, bus0.wr_en, 0);
    check_eq({tag, "_wr_col"}, bus0.wr_col, 0);
    check_eq({tag, "_wr_sign"}, bus0.wr_sign, 0);
    check_eq({tag, "_wr_mag"}, bus0.wr_mag, 0);
    check_eq({tag, "_wr_en1"}, bus1.wr_en, 0);
  endtask

  task automatic run_row(input int stall_col, input int stall_len, input bit rand_stall,
                         input bit poke_start);
    int  k = 0;
    int  c = 0;
    int  stalled = 0;
    int  stall_total = 0;
    bit  done_seen = 1'b0;
    bit  exp_wr;
    bit  ready;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done_seen && c < 200) begin
      exp_wr = (c >= int'(DEG) + 2) && (k < int'(DEG));
      check_eq("rd_en", bus0.rd_en, (c < int'(DEG)) ? 1 : 0);
      check_eq("rd_col", bus0.rd_col, (c < int'(DEG)) ? c : 0);
      check_eq("load_temp", bus0.load_temp, (c >= 1 && c <= int'(DEG)) ? 1 : 0);
      check_eq("busy", bus0.busy, 1);
      check_eq("done", bus0.done, (k == int'(DEG)) ? 1 : 0);
      check_eq("wr_en", bus0.wr_en, exp_wr);
      check_eq("wr_col", bus0.wr_col, exp_wr ? k : 0);
      check_eq("wr_mag", bus0.wr_mag, exp_wr ? exp_mag(k, 0) : 0);
      check_eq("wr_sign", bus0.wr_sign, exp_wr ? exp_sign(k) : 0);
      check_eq("wr_mag_off", bus1.wr_mag, exp_wr ? exp_mag(k, OFF1) : 0);
      check_eq("wr_sign_off", bus1.wr_sign, exp_wr ? exp_sign(k) : 0);
      if (k == int'(DEG)) begin
        done_seen = 1'b1;
        check_eq("done_cycle", c, 2 * DEG + 2 + stall_total);
      end
      start = poke_start && (c == 3 || c == int'(DEG) + 3);
      if (exp_wr && k == stall_col && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
      end else if (exp_wr && rand_stall) begin
        ready = ($urandom_range(0, 3) != 0);
      end else if (exp_wr) begin
        ready = 1'b1;
      end else begin
        ready = 1'($urandom_range(0, 1));
      end
      if (exp_wr && !ready) stall_total++;
      wr_ready = ready;
      @(negedge clk);
      if (exp_wr && ready) k++;
      c++;
    end
    start = 1'b0;
    if (!done_seen) check_eq("done_timeout", 0, 1);
    check_idle_outputs("post_row");
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // T1 / T3: base row; the offset-3 instance exercises saturation at zero.
    mag_a = '{5, 2, 9, 4, 7, 12};
    sig_a = '{0, 1, 1, 0, 0, 0};
    run_row(-1, 0, 1'b0, 1'b0);

    // T2: odd sign parity.
    sig_a = '{0, 1, 1, 0, 0, 1};
    run_row(-1, 0, 1'b0, 1'b0);

    // T4: tied minima.
    mag_a = '{3, 3, 8, 8, 8, 8};
    sig_a = '{0, 0, 0, 0, 0, 0};
    run_row(-1, 0, 1'b0, 1'b0);

    // T5: three-cycle stall on column 2 with start pulses while busy.
    mag_a = '{5, 2, 9, 4, 7, 12};
    sig_a = '{0, 1, 1, 0, 0, 0};
    run_row(2, 3, 1'b0, 1'b1);

    // T6: reset in the middle of collection, then a clean row.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_row(-1, 0, 1'b0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < DEG; j++) begin
        mag_a[j] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7))
                                               : int'($urandom_range(0, 255));
        sig_a[j] = 1'($urandom_range(0, 1));
      end
      run_row(int'($urandom_range(0, DEG - 1)), int'($urandom_range(0, 3)), 1'b1,
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
